// File: rtl/shifter_pkg.sv
// Shared types and elaboration-time helpers for the pipelined base-3 barrel shifter.
// Mode encoding, the 2-bit base-3 digit type and digit-count / bookkeeping functions.
package shifter_pkg;

    typedef enum logic [1:0] {
        MODE_SLL = 2'b00,
        MODE_SRL = 2'b01,
        MODE_SRA = 2'b10,
        MODE_ROR = 2'b11
    } mode_e;

    // One base-3 digit; only 0..2 are ever produced.
    typedef logic [1:0] digit_t;

    function automatic int pow3(input int k);
        int p = 1;
        for (int i = 0; i < k; i++) p = p * 3;
        return p;
    endfunction

    // Smallest n with 3^n > width, so every amount 0..width has an n-digit base-3 form.
    function automatic int calc_num_digits(input int width);
        int n = 0;
        int p = 1;
        while (p <= width) begin
            p = p * 3;
            n = n + 1;
        end
        return n;
    endfunction

    // Stage k keeps only the digits k+1..n-1 still to be applied; all stages share one
    // triangular array, and this maps (stage k, digit d) to its slot.
    function automatic int rem_idx(input int n, input int k, input int d);
        return k * (n - 1) - (k * (k - 1)) / 2 + d - k - 1;
    endfunction

endpackage

// File: rtl/shift_stage.sv
// One base-3 digit of the shifter: shifts data_in by digit * 3^STAGE through a 3:1 mux per bit.
// Rotate support is compiled in only when PIPELINED_SHIFTER_ROTATE_EN is defined.
module shift_stage
    import shifter_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int STAGE = 0
) (
    input  logic [WIDTH-1:0] data_in,
    input  mode_e            mode,
    input  digit_t           digit,
    output logic [WIDTH-1:0] data_out
);

    localparam int STEP = pow3(STAGE);

    // Called only with constant amounts, so each call reduces to fixed wiring.
    function automatic logic [WIDTH-1:0] shift_by(input logic [WIDTH-1:0] d,
                                                  input mode_e m,
                                                  input int amt);
        logic [WIDTH-1:0] r;
        case (m)
            MODE_SLL: r = d << amt;
            MODE_SRL: r = d >> amt;
            MODE_SRA: r = $signed(d) >>> amt;
`ifdef PIPELINED_SHIFTER_ROTATE_EN
            MODE_ROR: r = (d >> (amt % WIDTH)) | (d << ((WIDTH - amt % WIDTH) % WIDTH));
`endif
            default:  r = d;
        endcase
        return r;
    endfunction

    logic [WIDTH-1:0] sh_one;
    logic [WIDTH-1:0] sh_two;

    assign sh_one = shift_by(data_in, mode, STEP);
    assign sh_two = shift_by(data_in, mode, 2 * STEP);

    always_comb begin
        case (digit)
            2'd1:    data_out = sh_one;
            2'd2:    data_out = sh_two;
            default: data_out = data_in;
        endcase
    end

endmodule

// File: rtl/pipelined_shifter.sv
// Pipelined shifter (SLL/SRL/SRA/ROR) with one base-3 digit per stage and valid/ready flow control.
// Define PIPELINED_SHIFTER_ROTATE_EN to enable ROR; otherwise Mode 11 passes the operand through.
module pipelined_shifter
    import shifter_pkg::*;
#(
    parameter  int WIDTH = 16,
    parameter  int TAG_W = 4,
    localparam int SHW   = $clog2(WIDTH) + 1
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             InValid,
    output logic             InReady,
    input  logic [WIDTH-1:0] In,
    input  logic [SHW-1:0]   ShAmt,
    input  logic [1:0]       Mode,
    input  logic [TAG_W-1:0] TagIn,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] Out,
    output logic [TAG_W-1:0] TagOut
);

    localparam int NUM_DIGITS = calc_num_digits(WIDTH);
    localparam int REM_TOTAL  = NUM_DIGITS * (NUM_DIGITS - 1) / 2;

    mode_e            in_mode;
    logic [SHW-1:0]   amt_eff;
    digit_t           in_digits [NUM_DIGITS];
    logic             advance;

    logic [NUM_DIGITS-1:0] valid_q, valid_d;
    logic [WIDTH-1:0]      data_q  [NUM_DIGITS];
    logic [WIDTH-1:0]      data_d  [NUM_DIGITS];
    logic [TAG_W-1:0]      tag_q   [NUM_DIGITS];
    logic [TAG_W-1:0]      tag_d   [NUM_DIGITS];
    mode_e                 mode_q  [NUM_DIGITS-1];
    mode_e                 mode_d  [NUM_DIGITS-1];
    digit_t                rem_q   [REM_TOTAL];
    digit_t                rem_d   [REM_TOTAL];

    logic [WIDTH-1:0] stage_in    [NUM_DIGITS];
    mode_e            stage_mode  [NUM_DIGITS];
    digit_t           stage_digit [NUM_DIGITS];
    logic [WIDTH-1:0] stage_out   [NUM_DIGITS];

    assign in_mode = mode_e'(Mode);

    // Logical/arithmetic shifts saturate at WIDTH (all fill); rotates wrap modulo WIDTH.
    always_comb begin
        amt_eff = (ShAmt > SHW'(WIDTH)) ? SHW'(WIDTH) : ShAmt;
        if (in_mode == MODE_ROR) begin
`ifdef PIPELINED_SHIFTER_ROTATE_EN
            amt_eff = ShAmt % SHW'(WIDTH);
`else
            amt_eff = '0;
`endif
        end
    end

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
        localparam int P = pow3(k);
        assign in_digits[k] = digit_t'((amt_eff / SHW'(P)) % SHW'(3));
    end

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign stage_in[k]    = In;
            assign stage_mode[k]  = in_mode;
            assign stage_digit[k] = in_digits[0];
        end else begin : g_next
            assign stage_in[k]    = data_q[k-1];
            assign stage_mode[k]  = mode_q[k-1];
            assign stage_digit[k] = rem_q[rem_idx(NUM_DIGITS, k - 1, k)];
        end

        shift_stage #(
            .WIDTH (WIDTH),
            .STAGE (k)
        ) u_stage (
            .data_in  (stage_in[k]),
            .mode     (stage_mode[k]),
            .digit    (stage_digit[k]),
            .data_out (stage_out[k])
        );
    end

    // A single global enable: the only back-pressure point is a held result at the output.
    assign OutValid = valid_q[NUM_DIGITS-1];
    assign Out      = data_q[NUM_DIGITS-1];
    assign TagOut   = tag_q[NUM_DIGITS-1];
    assign InReady  = !(OutValid && !OutReady);
    assign advance  = InReady;

    always_comb begin
        // NOTE: every _d starts as its _q, so a stalled cycle holds state and no path infers a latch.
        valid_d = valid_q;
        data_d  = data_q;
        tag_d   = tag_q;
        mode_d  = mode_q;
        rem_d   = rem_q;
        if (advance) begin
            valid_d[0] = InValid;
            data_d[0]  = stage_out[0];
            tag_d[0]   = TagIn;
            mode_d[0]  = in_mode;
            for (int d = 1; d < NUM_DIGITS; d++) begin
                rem_d[rem_idx(NUM_DIGITS, 0, d)] = in_digits[d];
            end
            for (int k = 1; k < NUM_DIGITS; k++) begin
                valid_d[k] = valid_q[k-1];
                data_d[k]  = stage_out[k];
                tag_d[k]   = tag_q[k-1];
            end
            for (int k = 1; k < NUM_DIGITS - 1; k++) begin
                mode_d[k] = mode_q[k-1];
                for (int d = k + 1; d < NUM_DIGITS; d++) begin
                    rem_d[rem_idx(NUM_DIGITS, k, d)] = rem_q[rem_idx(NUM_DIGITS, k - 1, d)];
                end
            end
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            // NOTE: the stage arrays are a handful of pipeline flops, not a RAM, so they are all
            // cleared; Out and TagOut must read zero while in reset.
            valid_q <= '0;
            for (int k = 0; k < NUM_DIGITS; k++) begin
                data_q[k] <= '0;
                tag_q[k]  <= '0;
            end
            for (int k = 0; k < NUM_DIGITS - 1; k++) begin
                mode_q[k] <= MODE_SLL;
            end
            for (int i = 0; i < REM_TOTAL; i++) begin
                rem_q[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking updates so every stage samples its neighbour's pre-edge value.
            valid_q <= valid_d;
            data_q  <= data_d;
            tag_q   <= tag_d;
            mode_q  <= mode_d;
            rem_q   <= rem_d;
        end
    end

endmodule

// File: tb/tb_pipelined_shifter.sv
// Directed self-checking bench for pipelined_shifter at WIDTH=16 (three base-3 stages).
// ROR expectations follow PIPELINED_SHIFTER_ROTATE_EN as seen by this compile.
module tb_pipelined_shifter;

    localparam int WIDTH = 16;
    localparam int TAG_W = 4;
    localparam int SHW   = 5;

    logic             Clk = 1'b0;
    logic             Rst;
    logic             InValid = 1'b0;
    logic             InReady;
    logic [WIDTH-1:0] In = '0;
    logic [SHW-1:0]   ShAmt = '0;
    logic [1:0]       Mode = 2'b00;
    logic [TAG_W-1:0] TagIn = '0;
    logic             OutValid;
    logic             OutReady = 1'b1;
    logic [WIDTH-1:0] Out;
    logic [TAG_W-1:0] TagOut;

    int errors = 0;
    int checks = 0;

    always #5 Clk = ~Clk;

    pipelined_shifter #(
        .WIDTH (WIDTH),
        .TAG_W (TAG_W)
    ) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .InValid  (InValid),
        .InReady  (InReady),
        .In       (In),
        .ShAmt    (ShAmt),
        .Mode     (Mode),
        .TagIn    (TagIn),
        .OutValid (OutValid),
        .OutReady (OutReady),
        .Out      (Out),
        .TagOut   (TagOut)
    );

    // Called at a falling edge; the operand is taken on the following rising edge.
    task automatic issue(input logic [15:0] d, input logic [4:0] a, input logic [1:0] m,
                         input logic [3:0] t);
        In      = d;
        ShAmt   = a;
        Mode    = m;
        TagIn   = t;
        InValid = 1'b1;
        @(posedge Clk);
    endtask

    // Counts falling edges after acceptance until OutValid; -1 if it never arrives.
    task automatic wait_out(output int cyc);
        bit seen = 1'b0;
        cyc = -1;
        for (int i = 1; i <= 20; i++) begin
            if (!seen) begin
                @(negedge Clk);
                InValid = 1'b0;
                if (OutValid === 1'b1) begin
                    cyc  = i;
                    seen = 1'b1;
                end
            end
        end
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        #2;
        checks++; if (OutValid !== 1'b0) begin errors++; $display("FAIL reset_outvalid: got %b want 0", OutValid); end
        checks++; if (Out !== 16'h0000) begin errors++; $display("FAIL reset_out: got %h want 0000", Out); end
        checks++; if (TagOut !== 4'h0) begin errors++; $display("FAIL reset_tag: got %h want 0", TagOut); end
        checks++; if (InReady !== 1'b1) begin errors++; $display("FAIL reset_inready: got %b want 1", InReady); end
        InValid = 1'b1;
        In      = 16'hDEAD;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        checks++; if (OutValid !== 1'b0) begin errors++; $display("FAIL reset_hold_outvalid: got %b want 0", OutValid); end
        InValid = 1'b0;
        Rst     = 1'b0;
        #1;
        checks++; if (InReady !== 1'b1) begin errors++; $display("FAIL reset_release_inready: got %b want 1", InReady); end
    endtask

    task automatic test_shifts();
        logic [1:0]  vm [18];
        logic [15:0] vi [18];
        logic [4:0]  va [18];
        logic [15:0] ve [18];
        int cyc;
        vm = '{2'd2, 2'd1, 2'd0, 2'd2, 2'd3, 2'd0, 2'd2, 2'd3, 2'd0,
               2'd1, 2'd2, 2'd2, 2'd0, 2'd2, 2'd3, 2'd3, 2'd1, 2'd3};
        vi = '{16'h8000, 16'h8000, 16'h0001, 16'h8001, 16'h1234, 16'hABCD, 16'h8421, 16'h5A5A, 16'h00F3,
               16'hF000, 16'h7FFF, 16'h8000, 16'h1234, 16'hC350, 16'h8001, 16'h1234, 16'h1234, 16'h1234};
        va = '{5'd15, 5'd15, 5'd20, 5'd31, 5'd20, 5'd0, 5'd0, 5'd0, 5'd4,
               5'd16, 5'd16, 5'd16, 5'd7, 5'd5, 5'd1, 5'd16, 5'd31, 5'd31};
        ve = '{16'hFFFF, 16'h0001, 16'h0000, 16'hFFFF, 16'h1234, 16'hABCD, 16'h8421, 16'h5A5A, 16'h0F30,
               16'h0000, 16'h0000, 16'hFFFF, 16'h1A00, 16'hFE1A, 16'h8001, 16'h1234, 16'h0000, 16'h1234};
`ifdef PIPELINED_SHIFTER_ROTATE_EN
        ve[4]  = 16'h4123;
        ve[14] = 16'hC000;
        ve[17] = 16'h2468;
`endif
        OutReady = 1'b1;
        @(negedge Clk);
        for (int i = 0; i < 18; i++) begin
            issue(vi[i], va[i], vm[i], 4'(i));
            wait_out(cyc);
            checks++; if (cyc !== 3) begin errors++; $display("FAIL shift_latency[%0d]: got %0d cycles want 3", i, cyc); end
            checks++; if (Out !== ve[i]) begin errors++; $display("FAIL shift_out[%0d] mode=%0d in=%h amt=%0d: got %h want %h", i, vm[i], vi[i], va[i], Out, ve[i]); end
            checks++; if (TagOut !== 4'(i)) begin errors++; $display("FAIL shift_tag[%0d]: got %h want %h", i, TagOut, 4'(i)); end
        end
    endtask

    task automatic test_throughput();
        logic [1:0]  vm [5];
        logic [15:0] vi [5];
        logic [4:0]  va [5];
        logic [15:0] ve [5];
        logic [3:0]  vt [5];
        vm = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd0};
        vi = '{16'h000F, 16'hFFFF, 16'h4000, 16'h9000, 16'h0101};
        va = '{5'd8, 5'd12, 5'd14, 5'd2, 5'd9};
        ve = '{16'h0F00, 16'h000F, 16'h0001, 16'hE400, 16'h0200};
        vt = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h9};
        OutReady = 1'b1;
        @(negedge Clk);
        for (int t = 0; t < 9; t++) begin
            if (t >= 3) begin
                if (t - 3 < 5) begin
                    checks++; if (OutValid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d]: got %b want 1", t - 3, OutValid); end
                    checks++; if (Out !== ve[t-3]) begin errors++; $display("FAIL stream_out[%0d]: got %h want %h", t - 3, Out, ve[t-3]); end
                    checks++; if (TagOut !== vt[t-3]) begin errors++; $display("FAIL stream_tag[%0d]: got %h want %h", t - 3, TagOut, vt[t-3]); end
                end else begin
                    checks++; if (OutValid !== 1'b0) begin errors++; $display("FAIL stream_drain: got %b want 0", OutValid); end
                end
            end
            if (t < 5) begin
                checks++; if (InReady !== 1'b1) begin errors++; $display("FAIL stream_inready[%0d]: got %b want 1", t, InReady); end
                In = vi[t]; ShAmt = va[t]; Mode = vm[t]; TagIn = vt[t]; InValid = 1'b1;
            end else begin
                InValid = 1'b0;
            end
            @(negedge Clk);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0]  vm [3];
        logic [15:0] vi [3];
        logic [4:0]  va [3];
        logic [15:0] ve [3];
        logic [3:0]  vt [3];
        vm = '{2'd0, 2'd1, 2'd2};
        vi = '{16'h0001, 16'h8000, 16'h8000};
        va = '{5'd1, 5'd3, 5'd3};
        ve = '{16'h0002, 16'h1000, 16'hF000};
        vt = '{4'h5, 4'h6, 4'h7};
        @(negedge Clk);
        OutReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (InReady !== 1'b1) begin errors++; $display("FAIL b2b_accept_ready[%0d]: got %b want 1", i, InReady); end
            In = vi[i]; ShAmt = va[i]; Mode = vm[i]; TagIn = vt[i]; InValid = 1'b1;
            @(negedge Clk);
        end
        InValid = 1'b0;
        for (int s = 0; s < 5; s++) begin
            checks++; if (OutValid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d]: got %b want 1", s, OutValid); end
            checks++; if (InReady !== 1'b0) begin errors++; $display("FAIL stall_inready[%0d]: got %b want 0", s, InReady); end
            checks++; if (Out !== ve[0]) begin errors++; $display("FAIL stall_out[%0d]: got %h want %h", s, Out, ve[0]); end
            checks++; if (TagOut !== vt[0]) begin errors++; $display("FAIL stall_tag[%0d]: got %h want %h", s, TagOut, vt[0]); end
            @(negedge Clk);
        end
        OutReady = 1'b1;
        #1;
        checks++; if (InReady !== 1'b1) begin errors++; $display("FAIL release_inready: got %b want 1", InReady); end
        for (int j = 0; j < 3; j++) begin
            checks++; if (OutValid !== 1'b1) begin errors++; $display("FAIL drain_valid[%0d]: got %b want 1", j, OutValid); end
            checks++; if (Out !== ve[j]) begin errors++; $display("FAIL drain_out[%0d]: got %h want %h", j, Out, ve[j]); end
            checks++; if (TagOut !== vt[j]) begin errors++; $display("FAIL drain_tag[%0d]: got %h want %h", j, TagOut, vt[j]); end
            @(negedge Clk);
        end
        checks++; if (OutValid !== 1'b0) begin errors++; $display("FAIL drain_empty: got %b want 0", OutValid); end
    endtask

    task automatic test_reset_mid();
        int cyc;
        @(negedge Clk);
        OutReady = 1'b0;
        In = 16'h0003; ShAmt = 5'd2; Mode = 2'd0; TagIn = 4'hA; InValid = 1'b1;
        @(negedge Clk);
        In = 16'hFFFF; ShAmt = 5'd1; Mode = 2'd1; TagIn = 4'hB;
        @(negedge Clk);
        InValid = 1'b0;
        @(negedge Clk);
        checks++; if (OutValid !== 1'b1) begin errors++; $display("FAIL midreset_pre_valid: got %b want 1", OutValid); end
        checks++; if (Out !== 16'h000C) begin errors++; $display("FAIL midreset_pre_out: got %h want 000c", Out); end
        #2;
        Rst = 1'b1;
        #1;
        checks++; if (OutValid !== 1'b0) begin errors++; $display("FAIL midreset_valid: got %b want 0", OutValid); end
        checks++; if (Out !== 16'h0000) begin errors++; $display("FAIL midreset_out: got %h want 0000", Out); end
        checks++; if (TagOut !== 4'h0) begin errors++; $display("FAIL midreset_tag: got %h want 0", TagOut); end
        checks++; if (InReady !== 1'b1) begin errors++; $display("FAIL midreset_inready: got %b want 1", InReady); end
        @(posedge Clk);
        @(negedge Clk);
        Rst      = 1'b0;
        OutReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            checks++; if (OutValid !== 1'b0) begin errors++; $display("FAIL midreset_stale[%0d]: got %b want 0", i, OutValid); end
        end
        issue(16'hA5A5, 5'd4, 2'd1, 4'hC);
        wait_out(cyc);
        checks++; if (cyc !== 3) begin errors++; $display("FAIL postreset_latency: got %0d cycles want 3", cyc); end
        checks++; if (Out !== 16'h0A5A) begin errors++; $display("FAIL postreset_out: got %h want 0a5a", Out); end
        checks++; if (TagOut !== 4'hC) begin errors++; $display("FAIL postreset_tag: got %h want c", TagOut); end
    endtask

    initial begin
        test_reset();
        test_shifts();
        test_throughput();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipelined_shifter.md
PIPELINED_SHIFTER -- requirements
Module: pipelined_shifter

Interface
REQ-001 SHALL take parameter WIDTH, default 16, giving the data width in bits (legal range 4..64).
REQ-002 SHALL take parameter TAG_W, default 4, giving the width of the opaque sideband tag carried alongside the data.
REQ-003 SHALL derive localparams SHW = $clog2(WIDTH)+1 and NUM_DIGITS = smallest n with 3^n > WIDTH (WIDTH=16 -> SHW=5, NUM_DIGITS=3).
REQ-004 Clk  input  1  clock; all state updates on the rising edge.
REQ-005 Rst  input  1  reset; asynchronous, active-high.
REQ-006 InValid  input  1  input operand valid.
REQ-007 InReady  output  1  block can accept an operand this cycle.
REQ-008 In  input  WIDTH  operand.
REQ-009 ShAmt  input  SHW  unsigned shift amount.
REQ-010 Mode  input  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 ROR.
REQ-011 TagIn  input  TAG_W  sideband tag, returned unchanged with the result.
REQ-012 OutValid  output  1  result valid.
REQ-013 OutReady  input  1  consumer accepts the result.
REQ-014 Out  output  WIDTH  shifted result.
REQ-015 TagOut  output  TAG_W  tag belonging to Out.

Function
REQ-016 An operand SHALL be accepted when InValid && InReady; a result SHALL be consumed when OutValid && OutReady.
REQ-017 Input stage SHALL clamp ShAmt to WIDTH for SLL/SRL/SRA, reduce it modulo WIDTH for ROR, and convert the result to NUM_DIGITS base-3 digits, each in 0..2 (digit value 3 never produced).
REQ-018 Pipeline stage k (k=0..NUM_DIGITS-1) SHALL shift by digit_k*3^k and register data, remaining digits, mode, tag and a valid bit.
REQ-019 Vacated bits: SLL/SRL SHALL fill with 0, SRA SHALL fill with the original In[WIDTH-1], ROR SHALL wrap around.
REQ-020 SHALL produce the result on Out exactly NUM_DIGITS cycles after acceptance when there is no stall.
REQ-021 SHALL sustain one operand per cycle when OutReady is held high.
REQ-022 Stall: while OutValid && !OutReady, all stages SHALL hold and InReady SHALL be 0; otherwise InReady SHALL be 1 (InReady = !(OutValid && !OutReady)).
REQ-023 Out and TagOut SHALL stay stable while OutValid && !OutReady.
REQ-024 Simultaneous accept and consume SHALL advance the whole pipeline with no bubble and no loss.
REQ-025 Empty stages (valid=0) SHALL advance freely; bubbles SHALL NOT block later operands.
REQ-026 ShAmt=0 in any mode SHALL return In unchanged; a clamped amount of WIDTH SHALL yield all-fill (0 or sign).

Reset
REQ-027 Asserting Rst SHALL clear all stage valid bits, OutValid, Out, TagOut and all data registers to 0 immediately, independent of Clk.
REQ-028 Reset mid-operation SHALL discard every in-flight operand; the first accept after deassertion SHALL be handled normally.
REQ-029 InReady SHALL read 1 during and immediately after reset.

Configuration
REQ-030 Macro PIPELINED_SHIFTER_ROTATE_EN: when defined, Mode 11 SHALL perform ROR per REQ-017/REQ-019.
REQ-031 When PIPELINED_SHIFTER_ROTATE_EN is undefined, Mode 11 SHALL pass In through unshifted (effective amount 0), and no wrap-around logic SHALL be synthesised.

Structure
REQ-032 Package shifter_pkg SHALL hold the Mode encoding enum, digit typedef (2-bit, 0..2) and the NUM_DIGITS computation function.
REQ-033 Sub-module shift_stage (one base-3 digit, 3:1 mux per bit, parameters WIDTH and STAGE) SHALL be instantiated NUM_DIGITS times by generate.

Verification (WIDTH=16)
REQ-034 SRA In=0x8000 ShAmt=15 -> Out=0xFFFF after 3 cycles; SRL same operands -> 0x0001.
REQ-035 SLL In=0x0001 ShAmt=20 (clamped to 16) -> 0x0000; SRA In=0x8001 ShAmt=31 -> 0xFFFF.
REQ-036 ROR (macro defined) In=0x1234 ShAmt=20 -> 0x4123; macro undefined -> 0x1234.
REQ-037 Back-to-back stream of 3 operands, then OutReady=0 for 5 cycles -> InReady=0, Out stable, all 3 results delivered in order with matching TagOut.
REQ-038 Rst pulsed with 2 operands in flight -> OutValid=0 at once, no stale result after release, next operand correct after 3 cycles.
